// File: rtl/axis_fifo_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream packet FIFO.
package axis_fifo_pkg;

  localparam int DROP_COUNT_WIDTH = 16;

  typedef enum logic {
    NORMAL = 1'b0,
    DROP   = 1'b1
  } pkt_state_e;

  // Bits per stored entry: {tdata, tstrb, tkeep, tlast, tdest, tid, tuser}
  function automatic int entry_width(input int data_w, input int user_w,
                                     input int dest_w, input int id_w);
    return data_w + 2 * (data_w / 8) + 1 + dest_w + id_w + user_w;
  endfunction

  // Pointer width: address bits plus one wrap bit
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, asynchronous read, no reset.
module axis_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one entry per accepted write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with optional store-and-forward packet mode and drop-on-overflow.
module axis_packet_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 8,
  parameter int USER_WIDTH  = 4,
  parameter int DEST_WIDTH  = 4,
  parameter int ID_WIDTH    = 4,
  parameter int PACKET_MODE = 0,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int PTR_WIDTH  = ptr_width(DEPTH)
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]       s_axis_tstrb,
  input  logic [KEEP_WIDTH-1:0]       s_axis_tkeep,
  input  logic                        s_axis_tlast,
  input  logic [DEST_WIDTH-1:0]       s_axis_tdest,
  input  logic [ID_WIDTH-1:0]         s_axis_tid,
  input  logic [USER_WIDTH-1:0]       s_axis_tuser,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]       m_axis_tstrb,
  output logic [KEEP_WIDTH-1:0]       m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic [DEST_WIDTH-1:0]       m_axis_tdest,
  output logic [ID_WIDTH-1:0]         m_axis_tid,
  output logic [USER_WIDTH-1:0]       m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [PTR_WIDTH-1:0]        fifo_count,
  output logic [PTR_WIDTH-1:0]        pkt_count,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic                        drop_pulse,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam int ENTRY_W = entry_width(DATA_WIDTH, USER_WIDTH, DEST_WIDTH, ID_WIDTH);
  localparam int AW      = PTR_WIDTH - 1;
  localparam logic [PTR_WIDTH-1:0] DEPTH_P = PTR_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

  function automatic logic [DROP_COUNT_WIDTH-1:0] sat_inc(input logic [DROP_COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + DROP_COUNT_WIDTH'(1);
  endfunction

  logic [PTR_WIDTH-1:0]        wr_ptr, wr_commit, rd_ptr, limit, used;
  logic [PTR_WIDTH-1:0]        pkt_cnt;
  logic [DROP_COUNT_WIDTH-1:0] drop_cnt;
  logic                        drop_pls;
  pkt_state_e                  state, state_next;
  logic                        full, wr_fire, rd_fire, out_valid;
  logic                        wr_en, commit, drop, pkt_inc, pkt_dec;
  logic [ENTRY_W-1:0]          wr_entry, rd_entry;

  // Fullness counts uncommitted words; a same-cycle read never frees room for the write
  assign used      = wr_ptr - rd_ptr;
  assign full      = (used == DEPTH_P);
  assign limit     = (PACKET_MODE != 0) ? wr_commit : wr_ptr;
  assign out_valid = !areset && (rd_ptr != limit);

  assign s_axis_tready = !areset && ((PACKET_MODE != 0) || !full);
  assign wr_fire       = s_axis_tvalid && s_axis_tready;
  assign rd_fire       = out_valid && m_axis_tready;

  assign wr_entry = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                     s_axis_tdest, s_axis_tid, s_axis_tuser};

  axis_fifo_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (aclk),
    .we    (wr_en),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  // Output beat is forced to zero while nothing is readable so the unreset RAM never leaks X
  assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
          m_axis_tdest, m_axis_tid, m_axis_tuser} = out_valid ? rd_entry : '0;
  assign m_axis_tvalid = out_valid;

  // Drop FSM state register
  always_ff @(posedge aclk) begin
    if (areset) state <= NORMAL;
    else        state <= state_next;
  end

  // Drop FSM next state: an overflowing non-final beat swallows the rest of its packet
  always_comb begin
    state_next = state;
    if ((PACKET_MODE != 0) && wr_fire) begin
      case (state)
        NORMAL:  if (full && !s_axis_tlast) state_next = DROP;
        DROP:    if (s_axis_tlast)          state_next = NORMAL;
        default: state_next = NORMAL;
      endcase
    end
  end

  // Drop FSM outputs: decide whether the incoming beat is stored, committed or dropped
  always_comb begin
    wr_en  = 1'b0;
    commit = 1'b0;
    drop   = 1'b0;
    if (wr_fire) begin
      if (PACKET_MODE == 0) begin
        wr_en  = 1'b1;
        commit = s_axis_tlast;
      end else if (state == NORMAL) begin
        if (full) begin
          drop = 1'b1;
        end else begin
          wr_en  = 1'b1;
          commit = s_axis_tlast;
        end
      end
    end
  end

  // Pointers: a drop rewinds the write pointer to the last committed packet boundary
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      wr_commit <= '0;
      rd_ptr    <= '0;
    end else begin
      if (drop)       wr_ptr <= wr_commit;
      else if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (wr_en && (commit || (PACKET_MODE == 0))) wr_commit <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign pkt_inc = wr_en && commit;
  assign pkt_dec = rd_fire && m_axis_tlast;

  // Complete-packet count plus drop accounting
  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt  <= '0;
      drop_pls <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (pkt_inc && !pkt_dec)      pkt_cnt <= pkt_cnt + PTR_ONE;
      else if (pkt_dec && !pkt_inc) pkt_cnt <= pkt_cnt - PTR_ONE;
      drop_pls <= drop;
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  assign fifo_count = areset ? '0 : used;
  assign fifo_full  = !areset && full;
  assign fifo_empty = !out_valid;
  assign pkt_count  = areset ? '0 : pkt_cnt;
  assign drop_pulse = !areset && drop_pls;
  assign drop_count = areset ? '0 : drop_cnt;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Bench for axis_packet_fifo: one cut-through and one packet-mode instance side by side.
module tb_axis_packet_fifo;

  localparam int DEPTH = 8;
  localparam int PW    = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
    logic [3:0]  dest;
    logic [3:0]  id;
    logic [3:0]  user;
  } beat_t;

  logic  clk = 1'b0;
  logic  areset = 1'b1;
  beat_t s_beat [2];
  logic  s_valid [2];
  logic  m_ready [2];
  logic  s_ready [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_strb [2], m_keep [2], m_dest [2], m_id [2], m_user [2];
  logic        m_last [2], m_valid [2], ffull [2], fempty [2], dpulse [2];
  logic [PW-1:0] fcount [2], pcount [2];
  logic [15:0]   dcount [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_packet_fifo #(
      .DATA_WIDTH(32), .DEPTH(DEPTH), .USER_WIDTH(4), .DEST_WIDTH(4),
      .ID_WIDTH(4), .PACKET_MODE(g)
    ) dut (
      .aclk(clk), .areset(areset),
      .s_axis_tdata(s_beat[g].data), .s_axis_tstrb(s_beat[g].strb),
      .s_axis_tkeep(s_beat[g].keep), .s_axis_tlast(s_beat[g].last),
      .s_axis_tdest(s_beat[g].dest), .s_axis_tid(s_beat[g].id),
      .s_axis_tuser(s_beat[g].user), .s_axis_tvalid(s_valid[g]),
      .s_axis_tready(s_ready[g]),
      .m_axis_tdata(m_data[g]), .m_axis_tstrb(m_strb[g]), .m_axis_tkeep(m_keep[g]),
      .m_axis_tlast(m_last[g]), .m_axis_tdest(m_dest[g]), .m_axis_tid(m_id[g]),
      .m_axis_tuser(m_user[g]), .m_axis_tvalid(m_valid[g]), .m_axis_tready(m_ready[g]),
      .fifo_count(fcount[g]), .pkt_count(pcount[g]), .fifo_full(ffull[g]),
      .fifo_empty(fempty[g]), .drop_pulse(dpulse[g]), .drop_count(dcount[g])
    );
  end

  // Reference state: readable words per instance, the partial packet in packet mode,
  // and the scoreboard queues of beats still owed to the output
  beat_t store0[$], store1[$], part1[$], exp0[$], exp1[$];
  int    pk0 = 0, pk1 = 0, drops1 = 0, del1 = 0;
  bit    dropping = 1'b0, pulse1 = 1'b0, rand_rdy = 1'b0;
  int    checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: compare status outputs, then advance by the handshakes of the coming edge
  always @(negedge clk) begin
    int occ0, occ1;
    if (areset) begin
      chk("m0 tvalid in reset", m_valid[0], 1'b0);
      chk("m1 tvalid in reset", m_valid[1], 1'b0);
      chk("m0 tready in reset", s_ready[0], 1'b0);
      chk("m1 tready in reset", s_ready[1], 1'b0);
      store0.delete(); store1.delete(); part1.delete(); exp0.delete(); exp1.delete();
      pk0 = 0; pk1 = 0; drops1 = 0; dropping = 1'b0; pulse1 = 1'b0;
    end else begin
      occ0 = store0.size();
      occ1 = store1.size() + part1.size();
      chk("m0 tvalid", m_valid[0], occ0 != 0);
      chk("m0 tready", s_ready[0], occ0 < DEPTH);
      chk("m0 fifo_count", fcount[0], occ0);
      chk("m0 pkt_count", pcount[0], pk0);
      chk("m0 fifo_full", ffull[0], occ0 == DEPTH);
      chk("m0 fifo_empty", fempty[0], occ0 == 0);
      chk("m0 drop_pulse", dpulse[0], 1'b0);
      chk("m0 drop_count", dcount[0], 0);
      chk("m0 tdata known", $isunknown(m_data[0]), 1'b0);
      chk("m1 tvalid", m_valid[1], store1.size() != 0);
      chk("m1 tready", s_ready[1], 1'b1);
      chk("m1 fifo_count", fcount[1], occ1);
      chk("m1 pkt_count", pcount[1], pk1);
      chk("m1 fifo_full", ffull[1], occ1 == DEPTH);
      chk("m1 fifo_empty", fempty[1], store1.size() == 0);
      chk("m1 drop_pulse", dpulse[1], pulse1);
      chk("m1 drop_count", dcount[1], drops1);
      chk("m1 tdata known", $isunknown(m_data[1]), 1'b0);

      if (occ0 != 0 && m_ready[0]) begin
        if (store0[0].last) pk0--;
        void'(store0.pop_front());
      end
      if (s_valid[0] && occ0 < DEPTH) begin
        store0.push_back(s_beat[0]);
        exp0.push_back(s_beat[0]);
        if (s_beat[0].last) pk0++;
      end

      pulse1 = 1'b0;
      if (store1.size() != 0 && m_ready[1]) begin
        if (store1[0].last) pk1--;
        void'(store1.pop_front());
      end
      if (s_valid[1]) begin
        if (dropping) begin
          if (s_beat[1].last) dropping = 1'b0;
        end else if (occ1 == DEPTH) begin
          part1.delete();
          drops1++;
          pulse1 = 1'b1;
          dropping = !s_beat[1].last;
        end else begin
          part1.push_back(s_beat[1]);
          if (s_beat[1].last) begin
            foreach (part1[i]) begin
              store1.push_back(part1[i]);
              exp1.push_back(part1[i]);
            end
            part1.delete();
            pk1++;
          end
        end
      end
    end
  end

  // Scoreboard monitor: each output handshake must carry the oldest owed beat
  always @(negedge clk) begin
    beat_t got;
    if (!areset) begin
      for (int m = 0; m < 2; m++) begin
        if (m_valid[m] && m_ready[m]) begin
          got = {m_data[m], m_strb[m], m_keep[m], m_last[m], m_dest[m], m_id[m], m_user[m]};
          if (m == 0) begin
            if (exp0.size() == 0) chk("m0 unexpected beat", m_valid[m], 1'b0);
            else                  chk("m0 beat", got, exp0.pop_front());
          end else begin
            if (got.last) del1++;
            if (exp1.size() == 0) chk("m1 unexpected beat", m_valid[m], 1'b0);
            else                  chk("m1 beat", got, exp1.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rand_rdy) begin
      m_ready[0] = 1'($urandom_range(0, 1));
      m_ready[1] = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    b.data = $urandom;
    b.strb = 4'($urandom);
    b.keep = 4'($urandom);
    b.last = last;
    b.dest = 4'($urandom);
    b.id   = 4'($urandom);
    b.user = 4'($urandom);
    return b;
  endfunction

  task automatic send(input int m, input beat_t b);
    bit acc;
    int n;
    s_beat[m] = b;
    s_valid[m] = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_ready[m];
      tick();
      n++;
    end
    chk("beat accepted within budget", acc, 1'b1);
    s_valid[m] = 1'b0;
  endtask

  task automatic send_pkt(input int m, input int len, input bit gaps);
    for (int i = 0; i < len; i++) begin
      send(m, rand_beat(i == len - 1));
      if (gaps && $urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    beat_t b;
    int sent_r, base_del, base_drop;
    s_valid = '{1'b0, 1'b0};
    m_ready = '{1'b0, 1'b0};
    s_beat[0] = '0;
    s_beat[1] = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;

    // Cut-through: three beats held with the output stalled, then drained
    b = '0; b.strb = 4'hF; b.keep = 4'hF;
    b.data = 32'hDEADC0DE; b.last = 1'b1; b.dest = 4'h3; b.user = 4'h5;
    send(0, b);
    @(negedge clk); chk("t1 tvalid after first write", m_valid[0], 1'b1);
    tick();
    b.data = 32'hBADC0FFE; b.last = 1'b0; b.dest = 4'h7; b.user = 4'hA;
    send(0, b);
    b.data = 32'h12345678; b.last = 1'b1; b.dest = 4'h1; b.user = 4'h2;
    send(0, b);
    @(negedge clk);
    chk("t1 fifo_count", fcount[0], 3);
    chk("t1 pkt_count", pcount[0], 2);
    tick();
    m_ready[0] = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("t1 drained count", fcount[0], 0);
    chk("t1 drained pkt_count", pcount[0], 0);
    chk("t1 drained empty", fempty[0], 1'b1);
    tick();
    m_ready[0] = 1'b0;

    // Cut-through: fill, then read-only at full, then read and write together
    for (int i = 0; i < DEPTH; i++) send(0, rand_beat(i == DEPTH - 1));
    @(negedge clk);
    chk("t4 tready at full", s_ready[0], 1'b0);
    chk("t4 fifo_full", ffull[0], 1'b1);
    tick();
    s_beat[0] = rand_beat(1'b1); s_valid[0] = 1'b1; m_ready[0] = 1'b1;
    tick();
    @(negedge clk);
    chk("t4 count after read-only", fcount[0], 7);
    chk("t4 tready after read", s_ready[0], 1'b1);
    tick();
    s_valid[0] = 1'b0;
    @(negedge clk);
    chk("t4 count after read+write", fcount[0], 7);
    tick();
    repeat (10) tick();
    m_ready[0] = 1'b0;

    // Packet mode: output held until the tlast beat is written
    m_ready[1] = 1'b1;
    send(1, rand_beat(1'b0));
    @(negedge clk); chk("t2 tvalid after beat 1", m_valid[1], 1'b0);
    tick();
    send(1, rand_beat(1'b0));
    @(negedge clk); chk("t2 tvalid after beat 2", m_valid[1], 1'b0);
    tick();
    send(1, rand_beat(1'b1));
    @(negedge clk);
    chk("t2 tvalid after tlast", m_valid[1], 1'b1);
    chk("t2 pkt_count", pcount[1], 1);
    tick();
    repeat (4) tick();
    @(negedge clk); chk("t2 pkt_count drained", pcount[1], 0);
    tick();

    // Packet mode: oversized packet is dropped, next packet passes
    m_ready[1] = 1'b0;
    send_pkt(1, 10, 1'b0);
    @(negedge clk);
    chk("t3 fifo_count", fcount[1], 0);
    chk("t3 drop_count", dcount[1], 1);
    chk("t3 tvalid", m_valid[1], 1'b0);
    tick();
    m_ready[1] = 1'b1;
    send_pkt(1, 2, 1'b0);
    repeat (6) tick();
    @(negedge clk); chk("t3 short packet delivered", exp1.size(), 0);
    tick();

    // Packet mode: reset mid-packet
    m_ready[1] = 1'b0;
    for (int i = 0; i < 5; i++) send(1, rand_beat(1'b0));
    areset = 1'b1;
    tick();
    areset = 1'b0;
    @(negedge clk);
    chk("t5 fifo_count", fcount[1], 0);
    chk("t5 pkt_count", pcount[1], 0);
    chk("t5 fifo_empty", fempty[1], 1'b1);
    chk("t5 drop_count", dcount[1], 0);
    tick();
    m_ready[1] = 1'b1;
    send_pkt(1, 3, 1'b0);
    repeat (6) tick();
    @(negedge clk); chk("t5 packet after reset delivered", exp1.size(), 0);
    tick();

    // Random packets, cut-through
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) send_pkt(0, $urandom_range(1, 6), 1'b1);
    rand_rdy = 1'b0;
    m_ready = '{1'b1, 1'b1};
    repeat (20) tick();
    @(negedge clk);
    chk("r0 all delivered", exp0.size(), 0);
    chk("r0 fifo_count", fcount[0], 0);
    tick();

    // Random packets, packet mode
    base_del = del1;
    base_drop = dcount[1];
    sent_r = 0;
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      send_pkt(1, $urandom_range(1, 6), 1'b1);
      sent_r++;
    end
    rand_rdy = 1'b0;
    m_ready = '{1'b1, 1'b1};
    repeat (20) tick();
    @(negedge clk);
    chk("r1 all delivered", exp1.size(), 0);
    chk("r1 fifo_count", fcount[1], 0);
    chk("r1 dropped equals drop_count", dcount[1], base_drop + sent_r - (del1 - base_del));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
